// File: rtl/gpio_ctrl_bank_intr.sv
// Per-bank GPIO input conditioning: synchroniser, per-pin debounce filter,
// per-pin edge/level interrupt detection and sticky W1C status.
module gpio_ctrl_bank_intr #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      gpio_in,
  input  logic [WIDTH-1:0]      intr_enable,
  input  logic [2*WIDTH-1:0]    intr_mode,
  input  logic [DEBOUNCE_W-1:0] debounce_cycles,
  input  logic [WIDTH-1:0]      status_clr,
  output logic [WIDTH-1:0]      gpio_filtered,
  output logic [WIDTH-1:0]      intr_status,
  output logic                  bank_intr
);

  localparam logic [1:0] MODE_RISE  = 2'b00;
  localparam logic [1:0] MODE_FALL  = 2'b01;
  localparam logic [1:0] MODE_BOTH  = 2'b10;
  localparam logic [1:0] MODE_LEVEL = 2'b11;

  logic [WIDTH-1:0]      sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]      sync_d [SYNC_STAGES];
  logic [DEBOUNCE_W-1:0] cnt_q  [WIDTH];
  logic [DEBOUNCE_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0]      filtered_q, filtered_d;
  logic [WIDTH-1:0]      filtered_dly_q, filtered_dly_d;
  logic [WIDTH-1:0]      status_q, status_d;
  logic                  bank_intr_q, bank_intr_d;

  logic [WIDTH-1:0]      synced;
  logic [DEBOUNCE_W-1:0] thr_m1;
  logic [WIDTH-1:0]      rise, fall, set;

  // Plain flop chain; nothing may sit between stages.
  always_comb begin
    sync_d[0] = gpio_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // A zero threshold behaves as one, so T-1 saturates at zero.
  assign thr_m1 = (debounce_cycles == '0) ? '0 : debounce_cycles - 1'b1;

  // ">=" lets a threshold lowered below the running count commit at once.
  always_comb begin
    filtered_d = filtered_q;
    cnt_d      = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (synced[i] == filtered_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= thr_m1) begin
        filtered_d[i] = synced[i];
        cnt_d[i]      = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign rise = filtered_q & ~filtered_dly_q;
  assign fall = ~filtered_q & filtered_dly_q;

  always_comb begin
    set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (intr_mode[2*i +: 2])
        MODE_RISE:  set[i] = rise[i];
        MODE_FALL:  set[i] = fall[i];
        MODE_BOTH:  set[i] = rise[i] | fall[i];
        MODE_LEVEL: set[i] = filtered_q[i];
        default:    set[i] = 1'b0;
      endcase
    end
    set = set & intr_enable;
  end

  // Set is OR-ed in after the clear, so a coincident event wins.
  always_comb begin
    filtered_dly_d = filtered_q;
    status_d       = (status_q & ~status_clr) | set;
    bank_intr_d    = |status_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      filtered_q     <= '0;
      filtered_dly_q <= '0;
      status_q       <= '0;
      bank_intr_q    <= 1'b0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      filtered_q     <= filtered_d;
      filtered_dly_q <= filtered_dly_d;
      status_q       <= status_d;
      bank_intr_q    <= bank_intr_d;
    end
  end

  assign gpio_filtered = filtered_q;
  assign intr_status   = status_q;
  assign bank_intr     = bank_intr_q;

endmodule

// File: tb/tb_gpio_ctrl_bank_intr.sv
// Directed bench for gpio_ctrl_bank_intr: debounce latency, glitch rejection,
// interrupt modes, W1C collision, enable gating and asynchronous reset.
module tb_gpio_ctrl_bank_intr;

  localparam int WIDTH       = 32;
  localparam int SYNC_STAGES = 2;
  localparam int DEBOUNCE_W  = 8;

  logic                  clk;
  logic                  rst;
  logic [WIDTH-1:0]      gpio_in;
  logic [WIDTH-1:0]      intr_enable;
  logic [2*WIDTH-1:0]    intr_mode;
  logic [DEBOUNCE_W-1:0] debounce_cycles;
  logic [WIDTH-1:0]      status_clr;
  logic [WIDTH-1:0]      gpio_filtered;
  logic [WIDTH-1:0]      intr_status;
  logic                  bank_intr;

  int n_checks;
  int n_fail;

  gpio_ctrl_bank_intr #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_W  (DEBOUNCE_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .gpio_in         (gpio_in),
    .intr_enable     (intr_enable),
    .intr_mode       (intr_mode),
    .debounce_cycles (debounce_cycles),
    .status_clr      (status_clr),
    .gpio_filtered   (gpio_filtered),
    .intr_status     (intr_status),
    .bank_intr       (bank_intr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_pins(input logic [WIDTH-1:0] mask);
    status_clr = mask;
    step(1);
    status_clr = '0;
  endtask

  initial begin
    int hi_cnt;
    logic [WIDTH-1:0] seen;
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    gpio_in         = '0;
    intr_enable     = '0;
    intr_mode       = '0;
    debounce_cycles = 8'd4;
    status_clr      = '0;
    step(2);
    check("reset_filtered", gpio_filtered, 32'h0);
    check("reset_status", intr_status, 32'h0);
    check("reset_bank_intr", {31'b0, bank_intr}, 32'h0);
    rst = 1'b0;
    step(2);

    // Debounce latency: SYNC_STAGES + T = 6 to filtered, 7 to status.
    intr_enable = 32'h1 << 3;
    gpio_in[3]  = 1'b1;
    step(5);
    check("lat_filt_early", gpio_filtered, 32'h0);
    step(1);
    check("lat_filt_6", gpio_filtered, 32'h0000_0008);
    check("lat_status_early", intr_status, 32'h0);
    step(1);
    check("lat_status_7", intr_status, 32'h0000_0008);
    check("lat_bank_intr_7", {31'b0, bank_intr}, 32'h1);
    clear_pins(32'h1 << 3);
    check("lat_cleared", intr_status, 32'h0);
    gpio_in[3] = 1'b0;
    step(8);
    check("lat_fall_no_set", intr_status, 32'h0);

    // Glitch rejection on pin 5: 3-cycle pulse vanishes, 4-cycle pulse passes.
    intr_enable = 32'h1 << 5;
    gpio_in[5]  = 1'b1;
    step(3);
    gpio_in[5]  = 1'b0;
    seen        = '0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      seen = seen | gpio_filtered;
    end
    check("glitch3_filtered", seen, 32'h0);
    check("glitch3_status", intr_status, 32'h0);
    gpio_in[5] = 1'b1;
    step(4);
    gpio_in[5] = 1'b0;
    hi_cnt     = 0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      if (gpio_filtered[5]) hi_cnt++;
    end
    check("pulse4_width", hi_cnt, 32'd4);
    check("pulse4_status", intr_status, 32'h0000_0020);
    clear_pins(32'h1 << 5);

    // Modes: pin0 falling, pin1 both, pin2 level; T = 1.
    debounce_cycles = 8'd0;
    intr_enable     = 32'h7;
    intr_mode[5:0]  = 6'b11_10_01;
    gpio_in[2:0]    = 3'b111;
    step(4);
    check("mode_rise", intr_status, 32'h0000_0006);
    clear_pins(32'h6);
    check("mode_clr_level_high", intr_status, 32'h0000_0004);
    gpio_in[2:0] = 3'b000;
    step(4);
    check("mode_fall", intr_status, 32'h0000_0007);
    clear_pins(32'h7);
    check("mode_clr_low", intr_status, 32'h0);
    intr_mode = '0;

    // W1C collision on pin 7.
    intr_enable = 32'h1 << 7;
    gpio_in[7]  = 1'b1;
    step(4);
    check("w1c_first_set", intr_status, 32'h0000_0080);
    gpio_in[7] = 1'b0;
    step(4);
    gpio_in[7] = 1'b1;
    step(3);
    clear_pins(32'h1 << 7);
    check("w1c_collide", intr_status, 32'h0000_0080);
    clear_pins(32'h1 << 7);
    check("w1c_idle_status", intr_status, 32'h0);
    check("w1c_idle_bank_intr", {31'b0, bank_intr}, 32'h0);

    // Enable gating on pin 9.
    intr_enable = '0;
    gpio_in[9]  = 1'b1;
    step(5);
    check("en_gated", intr_status, 32'h0);
    gpio_in[9] = 1'b0;
    step(5);
    intr_enable = 32'h1 << 9;
    gpio_in[9]  = 1'b1;
    step(4);
    check("en_set", intr_status, 32'h0000_0200);
    intr_enable = '0;
    step(3);
    check("en_hold", intr_status, 32'h0000_0200);
    clear_pins(32'h1 << 9);
    check("en_cleared", intr_status, 32'h0);

    // Asynchronous reset mid-count, then recovery with T = 2.
    debounce_cycles = 8'd4;
    intr_enable     = '1;
    intr_mode       = '0;
    gpio_in         = '1;
    step(4);
    rst = 1'b1;
    #1;
    check("arst_filtered", gpio_filtered, 32'h0);
    check("arst_status", intr_status, 32'h0);
    check("arst_bank_intr", {31'b0, bank_intr}, 32'h0);
    step(2);
    debounce_cycles = 8'd2;
    rst             = 1'b0;
    step(SYNC_STAGES + 2);
    check("rel_filtered", gpio_filtered, 32'hFFFF_FFFF);
    check("rel_status_early", intr_status, 32'h0);
    step(1);
    check("rel_status", intr_status, 32'hFFFF_FFFF);
    check("rel_bank_intr", {31'b0, bank_intr}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
